// File: rtl/fwd_stall_ctrl.sv
// Forwarding-select and stall controller for the 5-stage pipeline; owns the mult/div busy counter.
// Optional event counters (stall_cnt, fwd_cnt) are built when FWD_STALL_STATS_EN is defined.
module fwd_stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic        rs_use_d,
    input  logic        rt_use_d,
    input  logic        md_use_d,
    input  logic [4:0]  wa_e,
    input  logic        we_e,
    input  logic        load_e,
    input  logic [4:0]  wa_m,
    input  logic        we_m,
    input  logic        md_start_e,
    input  logic        md_op_e,
    output logic [1:0]  fwd_rs_sel_e,
    output logic [1:0]  fwd_rt_sel_e,
    output logic        stall,
`ifdef FWD_STALL_STATS_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] fwd_cnt,
`endif
    output logic        md_busy
);

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_M   = 2'b01;
    localparam logic [1:0] SEL_W   = 2'b10;

    logic [CNT_W-1:0] md_cnt;
    logic [CNT_W-1:0] md_cnt_nxt;
    logic [1:0]       rs_sel_nxt;
    logic [1:0]       rt_sel_nxt;
    logic [1:0]       rs_sel_ld;
    logic [1:0]       rt_sel_ld;
    logic             e_wr;
    logic             m_wr;
    logic             load_use;
    logic             md_stall;

    // Youngest producer wins; a load in E cannot forward yet, so it falls through to M/none.
    function automatic logic [1:0] sel_f(input logic rd_use, input logic [4:0] ra,
                                         input logic e_ok, input logic m_ok);
        logic [1:0] s;
        s = SEL_REG;
        if (rd_use && e_ok && (ra == wa_e))
            s = SEL_M;
        else if (rd_use && m_ok && (ra == wa_m))
            s = SEL_W;
        return s;
    endfunction

    always_comb begin
        e_wr       = 1'b0;
        m_wr       = 1'b0;
        load_use   = 1'b0;
        md_stall   = 1'b0;
        stall      = 1'b0;
        rs_sel_nxt = SEL_REG;
        rt_sel_nxt = SEL_REG;
        rs_sel_ld  = SEL_REG;
        rt_sel_ld  = SEL_REG;
        md_cnt_nxt = md_cnt;

        e_wr = we_e && (wa_e != 5'd0);
        m_wr = we_m && (wa_m != 5'd0);

        load_use = load_e && e_wr &&
                   ((rs_use_d && (rs_d == wa_e)) || (rt_use_d && (rt_d == wa_e)));
        md_stall = md_use_d && (md_busy || md_start_e);
        stall    = rst_n && (load_use || md_stall);

        rs_sel_nxt = sel_f(rs_use_d, rs_d, e_wr && !load_e, m_wr);
        rt_sel_nxt = sel_f(rt_use_d, rt_d, e_wr && !load_e, m_wr);

        // A stall inserts a bubble into E, so the bubble must not forward.
        if (!stall) begin
            rs_sel_ld = rs_sel_nxt;
            rt_sel_ld = rt_sel_nxt;
        end

        // Starts while busy are ignored; the stall keeps the pipeline from issuing them.
        if (md_start_e && (md_cnt == '0))
            md_cnt_nxt = md_op_e ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        else if (md_cnt != '0)
            md_cnt_nxt = md_cnt - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_rs_sel_e <= SEL_REG;
            fwd_rt_sel_e <= SEL_REG;
            md_cnt       <= '0;
            md_busy      <= 1'b0;
        end else begin
            fwd_rs_sel_e <= rs_sel_ld;
            fwd_rt_sel_e <= rt_sel_ld;
            md_cnt       <= md_cnt_nxt;
            md_busy      <= (md_cnt_nxt != '0);
        end
    end

`ifdef FWD_STALL_STATS_EN
    logic [1:0] fwd_inc;

    always_comb begin
        fwd_inc = {1'b0, (rs_sel_ld != SEL_REG)} + {1'b0, (rt_sel_ld != SEL_REG)};
    end

    // Event counters wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
            fwd_cnt   <= 32'd0;
        end else begin
            if (stall)
                stall_cnt <= stall_cnt + 32'd1;
            fwd_cnt <= fwd_cnt + 32'(fwd_inc);
        end
    end
`endif

endmodule

// File: doc/fwd_stall_ctrl.md
Name: fwd_stall_ctrl

Overview:
- Hazard controller for the 5-stage pipeline.
- Computes the 2-bit selects for the E-stage 3-way 32-bit operand muxes (rs and rt) one cycle ahead and registers them into E.
- Generates the pipeline stall for load-use hazards and multiply/divide-unit occupancy.
- Owns the mult/div busy counter; sits beside the D/E pipeline register.

Parameters:
MULT_CYCLES, 5, busy cycles after a multiply start (1..15)
DIV_CYCLES, 10, busy cycles after a divide start (1..15)
CNT_W, 4, busy counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous, active-low reset
rs_d  in  5  D-stage rs register number
rt_d  in  5  D-stage rt register number
rs_use_d  in  1  D-stage instruction reads rs in E
rt_use_d  in  1  D-stage instruction reads rt in E
md_use_d  in  1  D-stage is mult/div/mfhi/mflo/mthi/mtlo
wa_e  in  5  E-stage destination register
we_e  in  1  E-stage writes register file
load_e  in  1  E-stage instruction is a load
wa_m  in  5  M-stage destination register
we_m  in  1  M-stage writes register file
md_start_e  in  1  E-stage starts mult/div this cycle
md_op_e  in  1  0 = multiply, 1 = divide
fwd_rs_sel_e  out  2  rs operand mux select: 00 = register value, 01 = M result, 10 = W result
fwd_rt_sel_e  out  2  rt operand mux select, same encoding
stall  out  1  freeze PC and F/D register, insert bubble into E
md_busy  out  1  mult/div unit occupied

Behaviour:
- Reset (rst_n low, asynchronous): fwd_rs_sel_e = 00, fwd_rt_sel_e = 00, busy counter = 0, md_busy = 0.
- stall is combinational and is 0 during reset.
- Register $0 is never forwarded. Any match against address 0 yields select 00 and no stall.
- Load-use stall: asserted when load_e && we_e && wa_e != 0 and either of these holds:
  - rs_use_d && rs_d == wa_e
  - rt_use_d && rt_d == wa_e
- Mult/div stall: asserted when md_use_d && (md_busy || md_start_e).
- stall = load-use stall OR mult/div stall.
- Select computation for the rs operand; rt is identical using rt_d / rt_use_d:
  - If rs_use_d && we_e && wa_e != 0 && rs_d == wa_e && !load_e, next select = 01 (producer will be in M).
  - Else if rs_use_d && we_m && wa_m != 0 && rs_d == wa_m, next select = 10 (producer will be in W).
  - Else next select = 00.
  - The E-stage match has priority over the M-stage match (youngest producer wins).
- Select register update, each rising edge:
  - If stall = 1, both select registers load 00 (bubble in E).
  - Otherwise they load the computed values. Latency is exactly 1 cycle, D decision to E output.
- Busy counter:
  - On md_start_e && counter == 0, the counter loads MULT_CYCLES (md_op_e = 0) or DIV_CYCLES (md_op_e = 1).
  - Otherwise, a nonzero counter decrements by 1.
  - md_busy = (counter != 0), registered. It is high for exactly N cycles, starting the edge after the start.
- md_start_e while counter != 0 is ignored; the counter is not reloaded. The pipeline never produces this case because of the stall.
- Simultaneous load-use and mult/div stall: a single stall. The select registers still clear.
- Counter reaching 0 while md_use_d is pending: stall drops in that same cycle, because md_busy is already 0.
- Reset mid-operation: the counter is cleared immediately and md_busy falls without waiting for a clock edge.

Optional Feature:
FWD_STALL_STATS_EN
- Defined:
  - Add outputs stall_cnt (32 bits) and fwd_cnt (32 bits), both cleared by rst_n.
  - stall_cnt increments every cycle stall = 1.
  - fwd_cnt increments every edge on which a nonzero select is loaded; if both rs and rt selects are nonzero, it increments by 2.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters are absent, and the remaining behaviour is identical.

Test Plan:
- E-stage match: rs_d = 8, rs_use_d = 1, wa_e = 8, we_e = 1, load_e = 0 -> next edge fwd_rs_sel_e = 01, stall = 0.
- M-stage match: rt_d = 9, rt_use_d = 1, wa_m = 9, we_m = 1, no E match -> next edge fwd_rt_sel_e = 10.
- E and M both match: wa_e = wa_m = 8 -> fwd_rs_sel_e = 01.
- Register $0: rs_d = 0 with wa_e = 0 -> fwd_rs_sel_e = 00.
- Load-use: load_e = 1, we_e = 1, wa_e = 5, rs_d = 5, rs_use_d = 1 -> stall = 1 for one cycle and both selects = 00.
  - The following cycle, with the load now in M (wa_m = 5) -> stall = 0, fwd_rs_sel_e = 10.
- Multiply: md_start_e = 1, md_op_e = 0 -> md_busy = 1 for exactly 5 cycles.
  - md_use_d held at 1 -> stall = 1 in the start cycle plus the 5 busy cycles (6 total), then 0.
  - Divide gives md_busy = 1 for 10 cycles.
- Reset mid-operation: drop rst_n 3 cycles into a divide -> md_busy = 0 and selects = 00 immediately, without a clock edge.
  - After release, a new multiply counts a full 5 cycles.
